// File: rtl/cla_34bit_pipe_stage_pkg.sv
// Shared constants, result type and carry-lookahead helper for the CLA pipeline stage.
package cla_34bit_pipe_stage_pkg;

    localparam int WIDTH_DEF     = 34;
    localparam int CNT_W_DEF     = 8;
    localparam int BUF_DEPTH_DEF = 2;

    localparam logic [1:0] OCC_LIMIT = 2'd3;

    typedef logic [WIDTH_DEF:0] result_t;

    // Carry out of bit k of a 4-bit group, expanded from the group carry-in only.
    function automatic logic cla_carry(input logic [3:0] g, input logic [3:0] p,
                                       input logic cin, input int k);
        logic c;
        c = cin;
        for (int j = 0; j < 4; j++) begin
            if (j <= k) begin
                c = g[j] | (p[j] & c);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/cla_34bit_pipe_stage_cla.sv
// Combinational carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_34bit
    import cla_34bit_pipe_stage_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int NG = (WIDTH + 3) / 4;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g    = a_i & b_i;
    assign p    = a_i ^ b_i;
    assign c[0] = cin_i;

    // The last group may be narrower than 4; its missing g/p bits are zero.
    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        localparam int LO = 4 * gi;
        localparam int N  = ((WIDTH - LO) < 4) ? (WIDTH - LO) : 4;
        logic [3:0] gg;
        logic [3:0] pp;
        assign gg = 4'(g[LO+N-1:LO]);
        assign pp = 4'(p[LO+N-1:LO]);
        for (genvar bi = 0; bi < N; bi++) begin : g_bit
            assign c[LO+bi+1] = cla_carry(gg, pp, c[LO], bi);
        end
    end

    assign sum_o  = p ^ c[WIDTH-1:0];
    assign cout_o = c[WIDTH];

endmodule

// File: rtl/cla_34bit_pipe_stage.sv
// Registered valid/ready stage around cla_34bit with a 2-entry result buffer and carry counter.
// Optional: define CLA_STAGE_PARITY_EN to add o_parity, stored per buffer entry.
module cla_34bit_pipe_stage
    import cla_34bit_pipe_stage_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    input  logic             i_clr_cnt,
    output logic [CNT_W-1:0] o_carry_cnt
`ifdef CLA_STAGE_PARITY_EN
    ,
    output logic             o_parity
`endif
);

    localparam logic [1:0]       DEPTH_L = BUF_DEPTH[1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [WIDTH-1:0] a_q, b_q;
    logic             stage_valid_q;
    logic [WIDTH:0]   buf_q [BUF_DEPTH_DEF];
    logic             wr_ptr_q, rd_ptr_q;
    logic [1:0]       count_q, count_d;
    logic [WIDTH:0]   last_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] sum_w;
    logic             cout_w;
    logic [WIDTH:0]   res_w;
    logic [1:0]       occ;
    logic             accept, pop, push;

    cla_34bit #(.WIDTH(WIDTH)) u_cla (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (1'b0),
        .sum_o  (sum_w),
        .cout_o (cout_w)
    );

    assign res_w = {cout_w, sum_w};

    // Ready depends only on registered occupancy, never on i_ready.
    assign occ     = count_q + {1'b0, stage_valid_q};
    assign o_ready = occ < OCC_LIMIT;
    assign o_valid = count_q != 2'd0;
    assign accept  = i_valid & o_ready;
    assign pop     = o_valid & i_ready;
    assign push    = stage_valid_q & ((count_q < DEPTH_L) | pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q           <= '0;
            b_q           <= '0;
            stage_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= i_add1;
                b_q <= i_add2;
            end
            stage_valid_q <= accept | (stage_valid_q & ~push);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH_DEF; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            last_q   <= '0;
        end else begin
            if (push) begin
                buf_q[wr_ptr_q] <= res_w;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                last_q   <= buf_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // When empty the output keeps showing the most recently popped result.
    assign o_result = o_valid ? buf_q[rd_ptr_q] : last_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_clr_cnt) begin
            cnt_q <= '0;
        end else if (push && res_w[WIDTH] && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign o_carry_cnt = cnt_q;

`ifdef CLA_STAGE_PARITY_EN
    logic buf_par_q [BUF_DEPTH_DEF];
    logic last_par_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH_DEF; i++) begin
                buf_par_q[i] <= 1'b0;
            end
            last_par_q <= 1'b0;
        end else begin
            if (push) begin
                buf_par_q[wr_ptr_q] <= ^res_w;
            end
            if (pop) begin
                last_par_q <= buf_par_q[rd_ptr_q];
            end
        end
    end

    assign o_parity = o_valid ? buf_par_q[rd_ptr_q] : last_par_q;
`endif

endmodule

// File: tb/tb_cla_34bit_pipe_stage.sv
// Randomized self-checking bench: in-flight queue model of the stage, checked every cycle.
module tb_cla_34bit_pipe_stage;
    import cla_34bit_pipe_stage_pkg::*;

    localparam logic [33:0] MAX34 = 34'h3_FFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [33:0] i_add1 = '0;
    logic [33:0] i_add2 = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [34:0] o_result;
    logic        i_clr_cnt = 1'b0;
    logic [7:0]  o_carry_cnt;
`ifdef CLA_STAGE_PARITY_EN
    logic        o_parity;
`endif

    cla_34bit_pipe_stage dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add1      (i_add1),
        .i_add2      (i_add2),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .i_clr_cnt   (i_clr_cnt),
        .o_carry_cnt (o_carry_cnt)
`ifdef CLA_STAGE_PARITY_EN
        ,
        .o_parity    (o_parity)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        result_t r;
        int      t;
    } item_t;

    item_t   q[$];
    result_t last_exp = '0;
    int      edge_cnt = 0;
    int      carry_acc = 0;
    int      n_cmp = 0;
    int      n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [33:0] a, input logic [33:0] b,
                         input logic r, input logic clr, output logic acc);
        logic exp_valid;
        logic popped;
        result_t sum;
        i_valid   = v;
        i_add1    = a;
        i_add2    = b;
        i_ready   = r;
        i_clr_cnt = clr;
        #1;
        exp_valid = (q.size() > 0) && ((edge_cnt - q[0].t) >= 1);
        check_val("o_ready", 64'(o_ready), 64'(q.size() < 3));
        check_val("o_valid", 64'(o_valid), 64'(exp_valid));
        if (exp_valid) begin
            check_val("head_result", 64'(o_result), 64'(q[0].r));
`ifdef CLA_STAGE_PARITY_EN
            check_val("head_parity", 64'(o_parity), 64'(^q[0].r));
`endif
        end else begin
            check_val("held_result", 64'(o_result), 64'(last_exp));
`ifdef CLA_STAGE_PARITY_EN
            check_val("held_parity", 64'(o_parity), 64'(^last_exp));
`endif
        end
        acc    = v && (q.size() < 3);
        popped = exp_valid && r;
        @(posedge i_clk);
        edge_cnt++;
        if (popped) begin
            last_exp = q[0].r;
            void'(q.pop_front());
        end
        if (acc) begin
            sum = {1'b0, a} + {1'b0, b};
            q.push_back('{r: sum, t: edge_cnt});
            if (sum[34]) carry_acc++;
        end
        if (clr) carry_acc = 0;
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        logic ok;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, ok);
    endtask

    task automatic check_cnt(input string tag);
        check_val(tag, 64'(o_carry_cnt), 64'((carry_acc > 255) ? 255 : carry_acc));
    endtask

    task automatic model_reset();
        q.delete();
        last_exp  = '0;
        carry_acc = 0;
    endtask

    initial begin
        logic        ok;
        int          k;
        logic [33:0] ra, rb;

        // Power-on reset
        repeat (3) @(negedge i_clk);
        check_val("rst_o_valid", 64'(o_valid), 64'(0));
        check_val("rst_o_result", 64'(o_result), 64'(0));
        check_val("rst_carry_cnt", 64'(o_carry_cnt), 64'(0));
        i_rst = 1'b0;
        model_reset();
        idle(2);

        // Basic add with carry out
        cycle(1'b1, MAX34, 34'h1, 1'b1, 1'b0, ok);
        idle(4);
        check_val("basic_last", 64'(last_exp), 64'h4_0000_0000);
        check_cnt("basic_carry_cnt");

        // Backpressure: 4 offered, 3 fit, then drain in order
        k = 1;
        for (int n = 0; n < 4; n++) begin
            cycle(1'b1, 34'(k), 34'(k), 1'b0, 1'b0, ok);
            if (ok) k++;
        end
        check_val("bp_accepted", 64'(k - 1), 64'(3));
        check_val("bp_full_ready", 64'(o_ready), 64'(0));
        for (int n = 0; n < 10; n++) begin
            cycle(k <= 4, 34'(k), 34'(k), 1'b1, 1'b0, ok);
            if (ok) k++;
        end
        check_val("bp_last", 64'(last_exp), 64'(8));

        // Reset with two results buffered and one in the stage
        for (int n = 0; n < 3; n++) cycle(1'b1, MAX34, MAX34, 1'b0, 1'b0, ok);
        #2 i_rst = 1'b1;
        #1;
        check_val("midrst_o_valid", 64'(o_valid), 64'(0));
        check_val("midrst_carry_cnt", 64'(o_carry_cnt), 64'(0));
        check_val("midrst_o_ready", 64'(o_ready), 64'(1));
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        idle(4);

        // Streaming: 100 random pairs, ready held high
        for (int n = 0; n < 100; n++) begin
            ra = 34'({$urandom, $urandom});
            rb = 34'({$urandom, $urandom});
            cycle(1'b1, ra, rb, 1'b1, 1'b0, ok);
            check_val("stream_accept", 64'(ok), 64'(1));
        end
        idle(3);

        // Random valid/ready traffic
        for (int n = 0; n < 300; n++) begin
            ra = 34'({$urandom, $urandom});
            rb = 34'({$urandom, $urandom});
            cycle(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), 1'b0, ok);
        end
        idle(4);
        check_cnt("random_carry_cnt");

        // Parity of small results
        cycle(1'b1, 34'h3, 34'h4, 1'b1, 1'b0, ok);
        cycle(1'b1, 34'h1, 34'h2, 1'b1, 1'b0, ok);
        idle(3);

        // Counter saturation
        for (int n = 0; n < 300; n++) cycle(1'b1, MAX34, MAX34, 1'b1, 1'b0, ok);
        idle(3);
        check_val("sat_carry_cnt", 64'(o_carry_cnt), 64'(255));
        check_cnt("sat_model_cnt");

        // Clear in the same cycle the carry result is written
        cycle(1'b1, MAX34, MAX34, 1'b1, 1'b0, ok);
        cycle(1'b0, '0, '0, 1'b1, 1'b1, ok);
        idle(2);
        check_val("clr_priority", 64'(o_carry_cnt), 64'(0));
        cycle(1'b1, MAX34, 34'h1, 1'b1, 1'b0, ok);
        idle(3);
        check_cnt("post_clr_cnt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
